// File: rtl/obstacle_pool_move.sv
// Pool of NUM_OBJ obstacle slots scrolling down the screen in fixed-point Y.
// Spawns fill the lowest free slot; a slot frees itself once it scrolls past MAX_Y.
module obstacle_pool_move #(
    parameter int NUM_OBJ    = 4,
    parameter int OBJ_H      = 128,
    parameter int MAX_Y      = 480,
    parameter int FRAC_BITS  = 6,
    parameter int SPEED_MULT = 16,
    parameter int REL_SPEED  = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [4:0]             speed,
    input  logic                   gameOver,
    input  logic                   spawn_req,
    input  logic [10:0]            spawn_x,
    output logic                   spawn_ack,
    output logic                   spawn_drop,
    output logic [2:0]             spawn_slot,
    output logic [NUM_OBJ-1:0]     obj_active,
    output logic [NUM_OBJ*11-1:0]  topLeftX,
    output logic [NUM_OBJ*11-1:0]  topLeftY,
    output logic [NUM_OBJ-1:0]     exit_pulse,
    output logic                   pool_full
);

    typedef enum logic [1:0] {
        RUN_ST = 2'd0,
        UPD_ST = 2'd1,
        LIM_ST = 2'd2
    } phase_t;

    localparam logic signed [17:0] Y_SPAWN = 18'(-(OBJ_H * (2 ** FRAC_BITS)));
    localparam logic signed [17:0] Y_LIMIT = 18'(MAX_Y);

    function automatic logic [4:0] rel_of(input logic [4:0] spd);
        if (spd > 5'(REL_SPEED)) begin
            return spd - 5'(REL_SPEED);
        end else begin
            return 5'd0;
        end
    endfunction

    phase_t                  phase_r, phase_nxt_s;
    logic signed [17:0]      y_r      [NUM_OBJ];
    logic signed [17:0]      y_nxt_s  [NUM_OBJ];
    logic [10:0]             x_nxt_s  [NUM_OBJ];
    logic [NUM_OBJ-1:0]      y_we_s;
    logic [NUM_OBJ-1:0]      act_nxt_s;
    logic [NUM_OBJ-1:0]      exit_nxt_s;
    logic [NUM_OBJ-1:0]      active_r;
    logic [NUM_OBJ-1:0]      move_mask_r;
    logic [NUM_OBJ-1:0]      exit_r;
    logic [NUM_OBJ*11-1:0]   tlx_r;
    logic [NUM_OBJ*11-1:0]   tly_r;
    logic                    ack_r;
    logic                    drop_r;
    logic [2:0]              slot_r;
    logic                    free_found_s;
    logic [2:0]              free_idx_s;
    logic                    accept_s;
    logic                    drop_s;
    logic [17:0]             inc_s;

    assign spawn_ack  = ack_r;
    assign spawn_drop = drop_r;
    assign spawn_slot = slot_r;
    assign obj_active = active_r;
    assign topLeftX   = tlx_r;
    assign topLeftY   = tly_r;
    assign exit_pulse = exit_r;
    assign pool_full  = &active_r;

    // Phase register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_r <= RUN_ST;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Phase sequencing; gameOver forces the pool back to idle
    always_comb begin
        phase_nxt_s = phase_r;
        if (gameOver) begin
            phase_nxt_s = RUN_ST;
        end else begin
            case (phase_r)
                RUN_ST:  phase_nxt_s = startOfFrame ? UPD_ST : RUN_ST;
                UPD_ST:  phase_nxt_s = LIM_ST;
                LIM_ST:  phase_nxt_s = RUN_ST;
                default: phase_nxt_s = RUN_ST;
            endcase
        end
    end

    // Lowest-index free slot and spawn decision
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = 3'd0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (!active_r[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = 3'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
        accept_s = spawn_req && !gameOver && (phase_r == RUN_ST) && free_found_s;
        drop_s   = spawn_req && !accept_s;
        inc_s    = 18'({13'd0, rel_of(speed)} * 18'(SPEED_MULT));
    end

    // Per-slot next state: clear, spawn, move, or retire past the bottom edge
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            y_nxt_s[i]    = y_r[i];
            x_nxt_s[i]    = tlx_r[11*i +: 11];
            y_we_s[i]     = 1'b0;
            act_nxt_s[i]  = active_r[i];
            exit_nxt_s[i] = 1'b0;
            if (gameOver) begin
                act_nxt_s[i] = 1'b0;
                y_nxt_s[i]   = Y_SPAWN;
                y_we_s[i]    = 1'b1;
            end else if (accept_s && (free_idx_s == 3'(i))) begin
                act_nxt_s[i] = 1'b1;
                x_nxt_s[i]   = spawn_x;
                y_nxt_s[i]   = Y_SPAWN;
                y_we_s[i]    = 1'b1;
            end else if ((phase_r == UPD_ST) && move_mask_r[i] && active_r[i]) begin
                y_nxt_s[i] = y_r[i] + $signed(inc_s);
                y_we_s[i]  = 1'b1;
            end else if ((phase_r == LIM_ST) && active_r[i] &&
                         ((y_r[i] >>> FRAC_BITS) >= Y_LIMIT)) begin
                act_nxt_s[i]  = 1'b0;
                exit_nxt_s[i] = 1'b1;
            end else begin
                y_we_s[i] = 1'b0;
            end
        end
    end

    // Slot state registers; move_mask freezes occupancy at frame start so a same-cycle spawn is not moved
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                y_r[i] <= Y_SPAWN;
            end
            active_r    <= '0;
            move_mask_r <= '0;
            exit_r      <= '0;
            tlx_r       <= '0;
            tly_r       <= '0;
            ack_r       <= 1'b0;
            drop_r      <= 1'b0;
            slot_r      <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                y_r[i]             <= y_nxt_s[i];
                tlx_r[11*i +: 11]  <= x_nxt_s[i];
                if (y_we_s[i]) begin
                    tly_r[11*i +: 11] <= 11'(y_nxt_s[i] >>> FRAC_BITS);
                end
            end
            active_r <= act_nxt_s;
            exit_r   <= exit_nxt_s;
            ack_r    <= accept_s;
            drop_r   <= drop_s;
            if (accept_s) begin
                slot_r <= free_idx_s;
            end
            if ((phase_r == RUN_ST) && startOfFrame && !gameOver) begin
                move_mask_r <= active_r;
            end
        end
    end

endmodule

// File: tb/tb_obstacle_pool_move.sv
// Directed-vector bench for obstacle_pool_move with hand-computed expectations.
module tb_obstacle_pool_move;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [4:0]  speed = 5'd0;
    logic        gameOver = 1'b0;
    logic        spawn_req = 1'b0;
    logic [10:0] spawn_x = 11'd0;
    logic        spawn_ack;
    logic        spawn_drop;
    logic [2:0]  spawn_slot;
    logic [3:0]  obj_active;
    logic [43:0] topLeftX;
    logic [43:0] topLeftY;
    logic [3:0]  exit_pulse;
    logic        pool_full;

    int n_vec = 0;
    int n_err = 0;

    obstacle_pool_move dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .speed(speed),
        .gameOver(gameOver), .spawn_req(spawn_req), .spawn_x(spawn_x),
        .spawn_ack(spawn_ack), .spawn_drop(spawn_drop), .spawn_slot(spawn_slot),
        .obj_active(obj_active), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .exit_pulse(exit_pulse), .pool_full(pool_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tly(input int i);
        return int'($signed(topLeftY[11*i +: 11]));
    endfunction

    function automatic int tlx(input int i);
        return int'(topLeftX[11*i +: 11]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic spawn(input int x);
        spawn_req = 1'b1;
        spawn_x   = 11'(x);
        tick();
        spawn_req = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        #2;
        do_reset();
        chk("rst_active", int'(obj_active), 0);
        chk("rst_tly0", tly(0), 0);
        chk("rst_ack", int'(spawn_ack), 0);
        chk("rst_full", int'(pool_full), 0);
        chk("rst_exit", int'(exit_pulse), 0);

        // 1. single object travels to the bottom and exits
        speed = 5'd10;
        spawn(200);
        chk("t1_ack", int'(spawn_ack), 1);
        chk("t1_slot", int'(spawn_slot), 0);
        chk("t1_y0", tly(0), -128);
        chk("t1_x0", tlx(0), 200);
        chk("t1_act", int'(obj_active), 1);
        tick();
        chk("t1_ack_pulse", int'(spawn_ack), 0);
        frames(1);
        chk("t1_y1", tly(0), -126);
        frames(302);
        chk("t1_y303", tly(0), 478);
        chk("t1_act303", int'(obj_active), 1);
        chk("t1_exit303", int'(exit_pulse), 0);
        frames(1);
        chk("t1_exit", int'(exit_pulse), 1);
        chk("t1_freed", int'(obj_active), 0);
        tick();
        chk("t1_exit_pulse", int'(exit_pulse), 0);

        // 2. fill all four slots, fifth is dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            spawn(10 + i);
            chk($sformatf("t2_ack%0d", i), int'(spawn_ack), 1);
            chk($sformatf("t2_slot%0d", i), int'(spawn_slot), i);
        end
        chk("t2_full", int'(pool_full), 1);
        spawn(999);
        chk("t2_drop", int'(spawn_drop), 1);
        chk("t2_noack", int'(spawn_ack), 0);
        chk("t2_slot_kept", int'(spawn_slot), 3);
        chk("t2_act", int'(obj_active), 15);
        chk("t2_x3", tlx(3), 13);

        // 3. speed at or below REL_SPEED does not move (no wrap)
        do_reset();
        spawn(50);
        speed = 5'd1;
        frames(10);
        chk("t3_s1", tly(0), -128);
        speed = 5'd2;
        frames(10);
        chk("t3_s2", tly(0), -128);

        // 4. spawn and frame start together
        do_reset();
        speed = 5'd10;
        spawn(40);
        frames(64);
        chk("t4_y0_zero", tly(0), 0);
        speed = 5'd6;
        spawn_req = 1'b1;
        spawn_x = 11'd300;
        startOfFrame = 1'b1;
        tick();
        spawn_req = 1'b0;
        startOfFrame = 1'b0;
        chk("t4_ack", int'(spawn_ack), 1);
        chk("t4_slot", int'(spawn_slot), 1);
        tick();
        tick();
        chk("t4_y0", tly(0), 1);
        chk("t4_y1", tly(1), -128);
        chk("t4_act", int'(obj_active), 3);

        // 5. gameOver clears the pool and refuses spawns
        do_reset();
        speed = 5'd10;
        spawn(1); spawn(2); spawn(3);
        chk("t5_act3", int'(obj_active), 7);
        gameOver = 1'b1;
        tick();
        chk("t5_clear", int'(obj_active), 0);
        chk("t5_noexit", int'(exit_pulse), 0);
        spawn_req = 1'b1;
        startOfFrame = 1'b1;
        tick();
        spawn_req = 1'b0;
        startOfFrame = 1'b0;
        chk("t5_drop", int'(spawn_drop), 1);
        chk("t5_still_clear", int'(obj_active), 0);
        gameOver = 1'b0;
        tick();

        // 6. hole left by slot1 is refilled first; then async reset mid-update
        do_reset();
        speed = 5'd31;
        spawn(100);
        frames(40);
        spawn(101);
        chk("t6_slot1", int'(spawn_slot), 1);
        frames(44);
        chk("t6_exit0", int'(exit_pulse), 1);
        spawn(102);
        chk("t6_reuse0", int'(spawn_slot), 0);
        spawn(103);
        chk("t6_slot2", int'(spawn_slot), 2);
        frames(40);
        chk("t6_exit1", int'(exit_pulse), 2);
        chk("t6_act", int'(obj_active), 5);
        spawn(104);
        chk("t6_fill1", int'(spawn_slot), 1);
        chk("t6_x1", tlx(1), 104);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        resetN = 1'b0;
        #1;
        chk("t6_rst_act", int'(obj_active), 0);
        chk("t6_rst_y", int'(topLeftY), 0);
        chk("t6_rst_x", int'(topLeftX), 0);
        chk("t6_rst_slot", int'(spawn_slot), 0);
        chk("t6_rst_full", int'(pool_full), 0);
        tick();
        resetN = 1'b1;
        tick();
        chk("t6_after_rst", int'(obj_active), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
